// File: rtl/output_argmax.sv
//==============================================================================
// Module      : output_argmax
// Description : Captures NUM_OUT signed neuron results when every per-neuron
//               ready bit is high, scans them one per cycle for the maximum
//               (lowest index wins ties) and presents the winning class index
//               and score on a valid/ready handshake. Partial ready sets and
//               results arriving while busy raise sticky error flags.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module output_argmax #(
    parameter int NUM_OUT = 4,
    parameter int DATA_W  = 17,
    parameter int IDX_W   = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_OUT-1:0]        result_ready,
    input  logic [NUM_OUT*DATA_W-1:0] results,
    input  logic                      class_ready,
    output logic                      class_valid,
    output logic [IDX_W-1:0]          class_idx,
    output logic [DATA_W-1:0]         class_score,
    output logic                      busy,
    output logic                      partial_err,
    output logic                      overrun_err,
    input  logic                      err_clr
);

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_OUT - 1);
    localparam logic [IDX_W-1:0] FIRST_PTR = IDX_W'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic signed [DATA_W-1:0] data_buf [NUM_OUT];
    logic signed [DATA_W-1:0] best_val;
    logic [IDX_W-1:0]         best_idx;
    logic [IDX_W-1:0]         ptr;

    logic all_ready;
    logic any_ready;
    logic partial_set;
    logic overrun_set;

    assign all_ready   = &result_ready;
    assign any_ready   = |result_ready;
    // A partial set is only meaningful while waiting; once busy, any ready is an overrun.
    assign partial_set = (state == S_IDLE) && any_ready && !all_ready;
    assign overrun_set = (state != S_IDLE) && any_ready;

    // State register; reset returns to IDLE immediately, abandoning any scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic: capture, one compare per cycle, hold until consumed.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (all_ready) begin
                    state_nxt = (NUM_OUT == 1) ? S_DONE : S_SCAN;
                end
            end
            S_SCAN: begin
                if (ptr == LAST_PTR) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (class_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Datapath: snapshot results on capture, then keep the running maximum.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                data_buf[k] <= '0;
            end
            best_val <= '0;
            best_idx <= '0;
            ptr      <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (all_ready) begin
                        for (int k = 0; k < NUM_OUT; k++) begin
                            data_buf[k] <= results[k*DATA_W +: DATA_W];
                        end
                        best_val <= results[0 +: DATA_W];
                        best_idx <= '0;
                        ptr      <= FIRST_PTR;
                    end
                end
                S_SCAN: begin
                    // Strictly greater so an equal later value never displaces a lower index.
                    if (data_buf[ptr] > best_val) begin
                        best_val <= data_buf[ptr];
                        best_idx <= ptr;
                    end
                    ptr <= ptr + FIRST_PTR;
                end
                default: begin
                end
            endcase
        end
    end

    // Sticky error flags; a fresh event outranks a simultaneous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            partial_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            partial_err <= partial_set | (partial_err & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

    // Outputs decode only registered state, so no input reaches them combinationally.
    assign class_valid = (state == S_DONE);
    assign busy        = (state != S_IDLE);
    assign class_idx   = class_valid ? best_idx : '0;
    assign class_score = class_valid ? best_val : '0;

endmodule

`default_nettype wire

// File: tb/tb_output_argmax.sv
//==============================================================================
// Module      : tb_output_argmax
// Description : Directed and randomised self-checking bench for output_argmax
//               with NUM_OUT=4, DATA_W=17.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_output_argmax;

    localparam int NUM_OUT = 4;
    localparam int DATA_W  = 17;
    localparam int IDX_W   = 2;

    logic                      clk;
    logic                      rst_n;
    logic [NUM_OUT-1:0]        result_ready;
    logic [NUM_OUT*DATA_W-1:0] results;
    logic                      class_ready;
    logic                      class_valid;
    logic [IDX_W-1:0]          class_idx;
    logic [DATA_W-1:0]         class_score;
    logic                      busy;
    logic                      partial_err;
    logic                      overrun_err;
    logic                      err_clr;

    int n_checks = 0;
    int n_fails  = 0;

    output_argmax #(
        .NUM_OUT (NUM_OUT),
        .DATA_W  (DATA_W),
        .IDX_W   (IDX_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .result_ready (result_ready),
        .results      (results),
        .class_ready  (class_ready),
        .class_valid  (class_valid),
        .class_idx    (class_idx),
        .class_score  (class_score),
        .busy         (busy),
        .partial_err  (partial_err),
        .overrun_err  (overrun_err),
        .err_clr      (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check, reports mismatches.
    task automatic check(input string tag, input logic signed [31:0] got, input logic signed [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a full ready set for exactly one cycle; returns #1 after edge E0.
    task automatic capture(input int a, input int b, input int c, input int d);
        logic [DATA_W-1:0] va, vb, vc, vd;
        va = a[DATA_W-1:0];
        vb = b[DATA_W-1:0];
        vc = c[DATA_W-1:0];
        vd = d[DATA_W-1:0];
        results      = {vd, vc, vb, va};
        result_ready = '1;
        tick();
        result_ready = '0;
    endtask

    // Wait for valid (expected 3 cycles after capture), check result, hold for
    // 'stall' cycles checking stability, then hand off and check the drop.
    task automatic expect_result(input string tag, input int exp_idx, input int exp_score, input int stall);
        int cnt;
        cnt = 0;
        check({tag, "_busy"}, busy, 1);
        while (!class_valid && cnt < 20) begin
            tick();
            cnt++;
        end
        check({tag, "_latency"}, cnt, 3);
        check({tag, "_idx"}, class_idx, exp_idx);
        check({tag, "_score"}, $signed(class_score), exp_score);
        for (int s = 0; s < stall; s++) begin
            tick();
            check({tag, "_hold_valid"}, class_valid, 1);
            check({tag, "_hold_idx"}, class_idx, exp_idx);
            check({tag, "_hold_score"}, $signed(class_score), exp_score);
        end
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        check({tag, "_drop_valid"}, class_valid, 0);
        check({tag, "_drop_busy"}, busy, 0);
    endtask

    int vals [NUM_OUT];
    int ref_idx;
    int ref_score;

    initial begin
        rst_n        = 1'b0;
        result_ready = '0;
        results      = '0;
        class_ready  = 1'b0;
        err_clr      = 1'b0;
        #12;
        check("rst_valid", class_valid, 0);
        check("rst_idx", class_idx, 0);
        check("rst_score", class_score, 0);
        check("rst_busy", busy, 0);
        check("rst_perr", partial_err, 0);
        check("rst_oerr", overrun_err, 0);
        rst_n = 1'b1;
        tick();

        // Basic maximum, one-cycle-wide valid
        capture(10, -5, 300, 299);
        expect_result("basic", 2, 300, 0);

        // Negatives and extremes, then tie at the positive limit
        capture(-65536, -1, -65536, -2);
        expect_result("neg", 1, -1, 0);
        capture(65535, 65535, -65536, 0);
        expect_result("tie", 0, 65535, 0);

        // Backpressure for 10 cycles
        capture(7, 8, 9, -9);
        expect_result("bp", 2, 9, 10);

        // Partial ready in IDLE: no capture, partial error set
        results      = '0;
        result_ready = 4'b0101;
        tick();
        result_ready = '0;
        check("partial_err", partial_err, 1);
        check("partial_busy", busy, 0);
        tick();
        tick();
        tick();
        check("partial_novalid", class_valid, 0);

        // Overrun during DONE: flag set, outputs untouched
        capture(1, 50, 50, 3);
        repeat (3) tick();
        check("ovr_pre_valid", class_valid, 1);
        results      = {17'd100, 17'd100, 17'd100, 17'd100};
        result_ready = '1;
        tick();
        result_ready = '0;
        check("ovr_err", overrun_err, 1);
        check("ovr_valid", class_valid, 1);
        check("ovr_idx", class_idx, 1);
        check("ovr_score", $signed(class_score), 50);
        class_ready = 1'b1;
        tick();
        class_ready = 1'b0;
        check("ovr_drop", class_valid, 0);

        // Clear both sticky errors
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_perr", partial_err, 0);
        check("clr_oerr", overrun_err, 0);

        // Reset one cycle after capture
        capture(100, 200, 300, 400);
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_valid", class_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_idx", class_idx, 0);
        check("midrst_score", class_score, 0);
        #6;
        rst_n = 1'b1;
        tick();
        capture(1, 2, 3, 4);
        expect_result("postrst", 3, 4, 0);

        // Randomised captures against a lowest-index-wins reference model
        for (int t = 0; t < 1000; t++) begin
            for (int k = 0; k < NUM_OUT; k++) begin
                logic [DATA_W-1:0] r;
                r = DATA_W'($urandom);
                if (t % 7 == 0) r = {15'd0, 2'(k % 2)};
                vals[k] = $signed(r);
            end
            ref_idx   = 0;
            ref_score = vals[0];
            for (int k = 1; k < NUM_OUT; k++) begin
                if (vals[k] > ref_score) begin
                    ref_score = vals[k];
                    ref_idx   = k;
                end
            end
            capture(vals[0], vals[1], vals[2], vals[3]);
            expect_result("rand", ref_idx, ref_score, int'($urandom_range(0, 3)));
        end
        check("rand_perr", partial_err, 0);
        check("rand_oerr", overrun_err, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    // Absolute time bound so the run always ends
    initial begin
        #2000000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
